// File: rtl/iodelay_ctrl_pkg.sv
// Shared types for the IODELAY tap controller: FSM state encoding and a
// width helper that never returns zero.
package iodelay_ctrl_pkg;

  localparam int state_width_lp = 3;

  typedef enum logic [state_width_lp-1:0] {
    HOLD     = 3'd0,
    WAIT_RDY = 3'd1,
    INIT     = 3'd2,
    IDLE     = 3'd3,
    LOAD     = 3'd4
  } state_e;

  function automatic int safe_clog2(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; a clear together with up loads one.
// The owner is responsible for any saturation by gating up_i.
module bsg_counter_clear_up
  import iodelay_ctrl_pkg::*;
#(
  parameter  int max_val_p = 15,
  localparam int width_lp  = safe_clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] count_r;

  // count register: reset, clear-then-step, or plain step
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= width_lp'(up_i);
    end else begin
      count_r <= count_r + width_lp'(up_i);
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/iodelay_tap_ctrl.sv
// IDELAYCTRL reset/ready sequencing plus shadowed VAR_LOAD tap updates for a
// bank of IDELAYE2 channels driven over one shared CNTVALUEIN bus.
module iodelay_tap_ctrl
  import iodelay_ctrl_pkg::*;
#(
  parameter  int channels_p        = 5,
  parameter  int tap_width_p       = 5,
  parameter  int init_tap_p        = 0,
  parameter  int rst_hold_cycles_p = 16,
  parameter  int rdy_timeout_p     = 1024,
  localparam int chan_width_lp     = safe_clog2(channels_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              idelayctrl_rdy_i,
  output logic                              idelayctrl_rst_o,
  input  logic                              tap_v_i,
  input  logic [chan_width_lp-1:0]          tap_chan_i,
  input  logic [tap_width_p-1:0]            tap_val_i,
  output logic                              tap_ready_o,
  output logic [channels_p-1:0]             ld_o,
  output logic [tap_width_p-1:0]            cntvalue_o,
  output logic [channels_p*tap_width_p-1:0] taps_o,
  output logic                              ready_o,
  output logic                              timeout_o
);

  localparam int cnt_max_lp   = ((rst_hold_cycles_p > rdy_timeout_p) ?
                                 rst_hold_cycles_p : rdy_timeout_p) - 1;
  localparam int cnt_width_lp = safe_clog2(cnt_max_lp + 1);

  localparam logic [cnt_width_lp-1:0]  hold_last_lp    = cnt_width_lp'(rst_hold_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0]  timeout_last_lp = cnt_width_lp'(rdy_timeout_p - 1);
  localparam logic [cnt_width_lp-1:0]  cnt_sat_lp      = cnt_width_lp'(cnt_max_lp);
  localparam logic [chan_width_lp-1:0] chan_last_lp    = chan_width_lp'(channels_p - 1);
  localparam logic [tap_width_p-1:0]   init_tap_lp     = tap_width_p'(init_tap_p);

  state_e                            state_r, state_n_s;
  logic [cnt_width_lp-1:0]           cnt_s;
  logic                              cnt_clear_s, cnt_up_s;
  logic [chan_width_lp-1:0]          chan_r, chan_n_s;
  logic [channels_p*tap_width_p-1:0] taps_r;
  logic                              tap_wr_s, timeout_set_s;
  logic [channels_p-1:0]             ld_n_s, ld_r;
  logic [tap_width_p-1:0]            cntval_n_s, cntval_r;
  logic                              rst_r, tap_ready_r, ready_r, timeout_r;

  // One counter times both HOLD and WAIT_RDY; it restarts on every state change
  // and stops at its top value instead of wrapping.
  assign cnt_clear_s = (state_n_s != state_r);
  assign cnt_up_s    = !cnt_clear_s && (cnt_s != cnt_sat_lp);

  bsg_counter_clear_up #(
    .max_val_p (cnt_max_lp)
  ) cycle_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear_s),
    .up_i    (cnt_up_s),
    .count_o (cnt_s)
  );

  // next-state logic and the output values the next state will present
  always_comb begin
    state_n_s     = state_r;
    chan_n_s      = chan_r;
    tap_wr_s      = 1'b0;
    timeout_set_s = 1'b0;
    ld_n_s        = '0;
    cntval_n_s    = '0;
    case (state_r)
      HOLD: begin
        if (cnt_s == hold_last_lp) begin
          state_n_s = WAIT_RDY;
        end else begin
          state_n_s = HOLD;
        end
      end
      WAIT_RDY: begin
        if (idelayctrl_rdy_i) begin
          state_n_s = INIT;
          chan_n_s  = '0;
        end else if (cnt_s == timeout_last_lp) begin
          state_n_s     = HOLD;
          timeout_set_s = 1'b1;
        end else begin
          state_n_s = WAIT_RDY;
        end
      end
      INIT: begin
        if (chan_r == chan_last_lp) begin
          state_n_s = IDLE;
        end else begin
          chan_n_s = chan_r + chan_width_lp'(1);
        end
      end
      IDLE: begin
        // an RDY drop outranks a request arriving in the same cycle
        if (!idelayctrl_rdy_i) begin
          state_n_s = WAIT_RDY;
        end else if (tap_v_i && (tap_chan_i <= chan_last_lp)) begin
          state_n_s = LOAD;
          tap_wr_s  = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      LOAD: begin
        if (idelayctrl_rdy_i) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = WAIT_RDY;
        end
      end
      default: begin
        state_n_s = HOLD;
      end
    endcase

    if (state_n_s == INIT) begin
      ld_n_s[chan_n_s] = 1'b1;
      cntval_n_s       = taps_r[chan_n_s*tap_width_p +: tap_width_p];
    end else if (tap_wr_s) begin
      ld_n_s[tap_chan_i] = 1'b1;
      cntval_n_s         = tap_val_i;
    end else begin
      ld_n_s     = '0;
      cntval_n_s = '0;
    end
  end

  // state, shadow taps and all registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= HOLD;
      chan_r      <= '0;
      taps_r      <= {channels_p{init_tap_lp}};
      ld_r        <= '0;
      cntval_r    <= '0;
      rst_r       <= 1'b1;
      tap_ready_r <= 1'b0;
      ready_r     <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      chan_r      <= chan_n_s;
      if (tap_wr_s) begin
        taps_r[tap_chan_i*tap_width_p +: tap_width_p] <= tap_val_i;
      end
      ld_r        <= ld_n_s;
      cntval_r    <= cntval_n_s;
      rst_r       <= (state_n_s == HOLD);
      tap_ready_r <= (state_n_s == IDLE);
      ready_r     <= (state_n_s == IDLE);
      timeout_r   <= timeout_r | timeout_set_s;
    end
  end

  assign idelayctrl_rst_o = rst_r;
  assign tap_ready_o      = tap_ready_r;
  assign ready_o          = ready_r;
  assign ld_o             = ld_r;
  assign cntvalue_o       = cntval_r;
  assign taps_o           = taps_r;
  assign timeout_o        = timeout_r;

endmodule
